// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage (master) and the data memory (slave).
interface mem_access_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ack;
    logic [63:0] dm_rdata;

    // dm_req stays high until the cycle dm_ack is seen; addr/wdata/we are stable while it waits.
    // dm_ack is only meaningful while dm_req=1, and dm_rdata only in the dm_ack cycle of a load.
    modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
    modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory accesses, stalls upstream until dm_ack, registers MEM/WB results.
// Optional macro MEM_TIMEOUT_EN adds a 15-cycle WAIT timeout that sets a sticky mem_err.
module mem_access_stage (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memWrite_E_MEM,
    input  logic                       MemToReg_MEM,
    input  logic                       regWrite_E_MEM,
    input  logic                       mem_read_MEM,
    input  logic                       shiftSel_MEM,
    input  logic [63:0]                ALU_out_MEM,
    input  logic [63:0]                mem_Din_MEM,
    input  logic [63:0]                shift_output_MEM,
    input  logic [4:0]                 regWrite_MEM,
    mem_access_stage_if.master         dm,
    output logic                       stall,
    output logic                       regWrite_E_WB,
    output logic [4:0]                 regWrite_WB,
    output logic [63:0]                wb_data_WB,
    output logic                       mem_err,
    output logic                       dbg_state
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;
    logic        op_present;
    logic        store;
    logic        load;
    logic        ack;
    logic        timeout_hit;
    logic [63:0] wb_mux;

    // Writeback selection does not need MemToReg: load-ness comes from mem_read/memWrite.
    logic unused_memtoreg;
    assign unused_memtoreg = MemToReg_MEM;

    assign op_present  = memWrite_E_MEM | mem_read_MEM;
    assign store       = memWrite_E_MEM;
    assign load        = mem_read_MEM & ~store;
    assign ack         = dm.dm_ack & op_present;

    assign dm.dm_req   = op_present;
    assign dm.dm_we    = store;
    assign dm.dm_addr  = ALU_out_MEM;
    assign dm.dm_wdata = mem_Din_MEM;

    assign wb_mux    = load ? dm.dm_rdata : (shiftSel_MEM ? shift_output_MEM : ALU_out_MEM);
    assign dbg_state = (state == S_WAIT);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] wait_cnt;
    // wait_cnt is 0 in the first WAIT cycle, so 14 marks the 15th consecutive WAIT cycle.
    assign timeout_hit = (state == S_WAIT) && (wait_cnt == 4'd14) && !ack;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    assign stall = op_present & ~ack & ~timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            regWrite_E_WB <= 1'b0;
            regWrite_WB   <= 5'd0;
            wb_data_WB    <= 64'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= 4'd0;
            mem_err       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_present && !ack) begin
                        state <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt <= 4'd0;
`endif
                    end
                end
                S_WAIT: begin
                    if (!op_present || ack || timeout_hit) begin
                        state <= S_IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase

            // Stalled or timed-out cycles send a bubble; register index and data hold.
            if (stall || timeout_hit) begin
                regWrite_E_WB <= 1'b0;
            end else begin
                regWrite_E_WB <= regWrite_E_MEM & (regWrite_MEM != 5'd31);
                regWrite_WB   <= regWrite_MEM;
                wb_data_WB    <= wb_mux;
            end

`ifdef MEM_TIMEOUT_EN
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (default build and MEM_TIMEOUT_EN build).
module tb_mem_access_stage;
    logic        clk;
    logic        reset;
    logic        memWrite_E_MEM, MemToReg_MEM, regWrite_E_MEM, mem_read_MEM, shiftSel_MEM;
    logic [63:0] ALU_out_MEM, mem_Din_MEM, shift_output_MEM;
    logic [4:0]  regWrite_MEM;
    logic        stall, regWrite_E_WB, mem_err, dbg_state;
    logic [4:0]  regWrite_WB;
    logic [63:0] wb_data_WB;

    mem_access_stage_if dm_bus ();

    mem_access_stage dut (
        .clk              (clk),
        .reset            (reset),
        .memWrite_E_MEM   (memWrite_E_MEM),
        .MemToReg_MEM     (MemToReg_MEM),
        .regWrite_E_MEM   (regWrite_E_MEM),
        .mem_read_MEM     (mem_read_MEM),
        .shiftSel_MEM     (shiftSel_MEM),
        .ALU_out_MEM      (ALU_out_MEM),
        .mem_Din_MEM      (mem_Din_MEM),
        .shift_output_MEM (shift_output_MEM),
        .regWrite_MEM     (regWrite_MEM),
        .dm               (dm_bus.master),
        .stall            (stall),
        .regWrite_E_WB    (regWrite_E_WB),
        .regWrite_WB      (regWrite_WB),
        .wb_data_WB       (wb_data_WB),
        .mem_err          (mem_err),
        .dbg_state        (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic clear_inputs();
        memWrite_E_MEM   = 1'b0;
        MemToReg_MEM     = 1'b0;
        regWrite_E_MEM   = 1'b0;
        mem_read_MEM     = 1'b0;
        shiftSel_MEM     = 1'b0;
        ALU_out_MEM      = 64'd0;
        mem_Din_MEM      = 64'd0;
        shift_output_MEM = 64'd0;
        regWrite_MEM     = 5'd0;
        dm_bus.dm_ack    = 1'b0;
        dm_bus.dm_rdata  = 64'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [63:0] addr, input logic [4:0] rd);
        clear_inputs();
        mem_read_MEM   = 1'b1;
        MemToReg_MEM   = 1'b1;
        regWrite_E_MEM = 1'b1;
        regWrite_MEM   = rd;
        ALU_out_MEM    = addr;
    endtask

    int stall_cycles;

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_e_wb", regWrite_E_WB, 0);
        check("rst_rd_wb", regWrite_WB, 0);
        check("rst_data_wb", wb_data_WB, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_state", dbg_state, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;
        tick();

        // zero-wait store
        memWrite_E_MEM = 1'b1; ALU_out_MEM = 64'h10; mem_Din_MEM = 64'hAB; dm_bus.dm_ack = 1'b1;
        @(negedge clk);
        check("st0_req", dm_bus.dm_req, 1);
        check("st0_we", dm_bus.dm_we, 1);
        check("st0_addr", dm_bus.dm_addr, 64'h10);
        check("st0_wdata", dm_bus.dm_wdata, 64'hAB);
        check("st0_stall", stall, 0);
        tick();
        check("st0_e_wb", regWrite_E_WB, 0);
        check("st0_state", dbg_state, 0);

        // ALU op to X31, then a shift op to X3
        clear_inputs();
        regWrite_E_MEM = 1'b1; regWrite_MEM = 5'd31; ALU_out_MEM = 64'd7;
        @(negedge clk);
        check("x31_req", dm_bus.dm_req, 0);
        check("x31_stall", stall, 0);
        tick();
        check("x31_e_wb", regWrite_E_WB, 0);
        check("x31_data", wb_data_WB, 64'd7);
        shiftSel_MEM = 1'b1; shift_output_MEM = 64'd9; regWrite_MEM = 5'd3;
        tick();
        check("sh_data", wb_data_WB, 64'd9);
        check("sh_e_wb", regWrite_E_WB, 1);
        check("sh_rd", regWrite_WB, 3);

        // 3-wait load; rdata garbage while waiting
        drive_load(64'h40, 5'd5);
        dm_bus.dm_rdata = 64'hDEAD;
        stall_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            check("ld3_req", dm_bus.dm_req, 1);
            tick();
            check("ld3_bubble", regWrite_E_WB, 0);
            dm_bus.dm_rdata = 64'hBEEF + 64'(i);
        end
        check("ld3_stall_cycles", stall_cycles, 3);
        check("ld3_hold_rd", regWrite_WB, 3);
        check("ld3_hold_data", wb_data_WB, 64'd9);
        check("ld3_state_wait", dbg_state, 1);
        dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 64'h1234;
        @(negedge clk);
        check("ld3_ack_stall", stall, 0);
        tick();
        check("ld3_rd", regWrite_WB, 5);
        check("ld3_data", wb_data_WB, 64'h1234);
        check("ld3_e_wb", regWrite_E_WB, 1);
        check("ld3_state_idle", dbg_state, 0);

        // back-to-back zero-wait store then load
        clear_inputs();
        memWrite_E_MEM = 1'b1; ALU_out_MEM = 64'h20; mem_Din_MEM = 64'h5A; dm_bus.dm_ack = 1'b1;
        @(negedge clk);
        check("b2b_st_req", dm_bus.dm_req, 1);
        tick();
        drive_load(64'h28, 5'd6);
        dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 64'h77;
        @(negedge clk);
        check("b2b_ld_req", dm_bus.dm_req, 1);
        check("b2b_ld_we", dm_bus.dm_we, 0);
        check("b2b_ld_stall", stall, 0);
        tick();
        check("b2b_ld_data", wb_data_WB, 64'h77);
        check("b2b_ld_rd", regWrite_WB, 6);

        // store+read both set: treated as store, ALU result written back
        clear_inputs();
        memWrite_E_MEM = 1'b1; mem_read_MEM = 1'b1; MemToReg_MEM = 1'b1;
        ALU_out_MEM = 64'h30; dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 64'hFF;
        @(negedge clk);
        check("both_we", dm_bus.dm_we, 1);
        tick();
        check("both_data", wb_data_WB, 64'h30);

        // back-to-back ALU/shift ops through the expected queue
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            regWrite_E_MEM   = 1'b1;
            regWrite_MEM     = 5'(i + 1);
            ALU_out_MEM      = 64'h100 + 64'(i * 3);
            shift_output_MEM = 64'h200 + 64'(i);
            shiftSel_MEM     = (i % 2) == 1;
            exp_q.push_back(((i % 2) == 1) ? 64'h200 + 64'(i) : 64'h100 + 64'(i * 3));
            tick();
            check("alu_seq_data", wb_data_WB, exp_q.pop_front());
            check("alu_seq_rd", regWrite_WB, 64'(i + 1));
        end

        // reset mid-WAIT; a late dm_ack with no op is ignored
        drive_load(64'h48, 5'd9);
        tick();
        check("rst_wait_state", dbg_state, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_e_wb", regWrite_E_WB, 0);
        check("arst_rd", regWrite_WB, 0);
        check("arst_data", wb_data_WB, 0);
        check("arst_state", dbg_state, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req", dm_bus.dm_req, 1);
        check("post_rst_stall", stall, 1);
        clear_inputs();
        regWrite_E_MEM = 1'b1; regWrite_MEM = 5'd4; ALU_out_MEM = 64'h55;
        dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 64'hBAD;
        #1;
        check("late_ack_req", dm_bus.dm_req, 0);
        check("late_ack_stall", stall, 0);
        tick();
        check("late_ack_state", dbg_state, 0);
        check("late_ack_data", wb_data_WB, 64'h55);
        check("late_ack_e_wb", regWrite_E_WB, 1);

        // load with no dm_ack
        drive_load(64'h80, 5'd7);
        @(negedge clk);
        check("to_first_stall", stall, 1);
        tick();
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("to_stall", stall, (k < 15) ? 1 : 0);
            tick();
        end
        check("to_state", dbg_state, 0);
        check("to_mem_err", mem_err, 1);
        check("to_e_wb", regWrite_E_WB, 0);
        clear_inputs();
        tick();
        check("to_mem_err_sticky", mem_err, 1);
`else
        stall_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            tick();
        end
        check("nto_stall_cycles", stall_cycles, 30);
        check("nto_state", dbg_state, 1);
        check("nto_mem_err", mem_err, 0);
        dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 64'hCAFE;
        @(negedge clk);
        check("nto_ack_stall", stall, 0);
        tick();
        check("nto_data", wb_data_WB, 64'hCAFE);
        check("nto_e_wb", regWrite_E_WB, 1);
        check("nto_state_idle", dbg_state, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have inputs from EX/MEM: memWrite_E_MEM, MemToReg_MEM, regWrite_E_MEM, mem_read_MEM, shiftSel_MEM (1 each); ALU_out_MEM, mem_Din_MEM, shift_output_MEM (64 each); regWrite_MEM (5).
REQ-004 SHALL have data-memory ports: dm_req out 1; dm_we out 1; dm_addr out 64 (= ALU_out_MEM); dm_wdata out 64 (= mem_Din_MEM); dm_ack in 1; dm_rdata in 64.
REQ-005 SHALL have outputs: stall out 1 (freezes upstream stages); regWrite_E_WB out 1; regWrite_WB out 5; wb_data_WB out 64; mem_err out 1.

Function
REQ-006 SHALL treat a cycle as a memory op when memWrite_E_MEM or mem_read_MEM is 1; if both are 1, the op is a store and MemToReg_MEM is ignored.
REQ-007 SHALL use FSM states IDLE and WAIT.
REQ-008 IDLE, op present: dm_req=1, dm_we=store; dm_ack=1 that cycle -> op completes with zero wait and the state stays IDLE; otherwise -> WAIT at the next edge.
REQ-009 WAIT: dm_req held at 1; dm_addr, dm_wdata and dm_we stable, because upstream inputs are frozen by stall; dm_ack=1 -> op completes and the state returns to IDLE at the next edge.
REQ-010 stall SHALL be combinational: stall = op_present AND NOT dm_ack (IDLE or WAIT); stall=0 when no op is present.
REQ-011 Non-memory cycle: dm_req=0, stall=0; the WB registers capture at the next edge (1-cycle latency).
REQ-012 Writeback data mux: wb_data = load ? dm_rdata : (shiftSel_MEM ? shift_output_MEM : ALU_out_MEM); a load is mem_read_MEM AND NOT store.
REQ-013 While stall=1, the WB registers SHALL capture a bubble (regWrite_E_WB=0; regWrite_WB and wb_data_WB hold previous values).
REQ-014 On completion or a non-memory cycle, regWrite_E_WB <= regWrite_E_MEM AND (regWrite_MEM != 31); X31 writes are suppressed.
REQ-015 A load SHALL capture dm_rdata on the dm_ack cycle edge; dm_rdata is don't-care in all other cycles.
REQ-016 dm_ack while dm_req=0 SHALL be ignored.
REQ-017 Each completed op SHALL issue exactly one access; back-to-back ops SHALL each assert dm_req starting in their first cycle.

Reset
REQ-018 reset=1 SHALL asynchronously force: state=IDLE, regWrite_E_WB=0, regWrite_WB=0, wb_data_WB=0, mem_err=0, and timeout counter=0.
REQ-019 Reset asserted during WAIT SHALL abandon the access; dm_req and stall follow the frozen inputs from IDLE after release.

Configuration
REQ-020 Macro MEM_TIMEOUT_EN, when defined, SHALL add a 4-bit WAIT-cycle counter that clears on entry to WAIT.
REQ-021 With MEM_TIMEOUT_EN defined, the 15th consecutive WAIT cycle without dm_ack SHALL force IDLE, set sticky mem_err=1, write a bubble to WB, and drop stall for that cycle so upstream advances.
REQ-022 Without MEM_TIMEOUT_EN, there SHALL be no counter, mem_err SHALL be tied to 0, and WAIT SHALL persist until dm_ack.

Verification
REQ-023 Zero-wait store: memWrite=1, ALU_out=0x10, mem_Din=0xAB, dm_ack=1 same cycle -> dm_req=dm_we=1, addr=0x10, wdata=0xAB, stall=0, regWrite_E_WB=0 after the edge.
REQ-024 3-wait load: mem_read=1, MemToReg=1, regWrite_MEM=5, dm_ack on 4th cycle with rdata=0x1234 -> stall=1 for 3 cycles; then regWrite_WB=5, wb_data_WB=0x1234, regWrite_E_WB=1.
REQ-025 ALU op to X31: regWrite_E=1, regWrite_MEM=31, ALU_out=7 -> regWrite_E_WB=0, wb_data_WB=7; shiftSel=1 with shift_output=9 -> wb_data_WB=9.
REQ-026 Reset pulse mid-WAIT -> all WB outputs read 0 immediately, state IDLE; a late dm_ack with no op is ignored.
REQ-027 MEM_TIMEOUT_EN defined, load with no dm_ack -> stall drops after 15 WAIT cycles, mem_err=1 stays set, regWrite_E_WB=0; without the macro, stall stays 1 indefinitely.
